lc3b_mem_seq: RTL and testbench

Parametrised memory-access sequencer for the LC-3b multicycle datapath. The control FSM hands it one request (read, write, indirect read or indirect write; word or byte). The block runs the whole memory handshake, including the pointer fetch for LDI/STI-style accesses, byte-lane selection and a wait-state timeout. It then returns a one-cycle completion pulse. It sits between the control FSM and the memory port and generalises the fixed 16-bit, two-lane, no-timeout access states of the current control unit.

---
 rtl/lc3b_mem_seq.sv | 192 +++++++++++++++++++
 tb/tb_lc3b_mem_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_seq.sv
// -----------------------------------------------------------------------------
// lc3b_mem_seq
// Memory-access sequencer for the LC-3b multicycle datapath. It accepts one
// request from the control FSM and runs the complete memory handshake: plain or
// indirect (pointer fetch, then data access), word or single-byte, with an
// optional per-phase wait-state timeout. It finishes with a one-cycle done pulse.
//
// Parameters
//   DATA_W   data width (multiple of 8, >= 16)
//   ADDR_W   address width
//   TIMEOUT  max wait cycles per access phase, 0 = never time out
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req                 request strobe (sampled only while idle)
//   req_op[1:0]         00 read, 01 write, 10 indirect read, 11 indirect write
//   req_byte            1 = byte access, 0 = word access
//   req_addr            access address (pointer address for indirect ops)
//   req_wdata           store data (byte 0 only for byte stores)
//   busy                high whenever not idle
//   done                one-cycle completion pulse
//   err                 timeout flag, only together with done
//   rdata               read result (byte reads zero-extended)
//   mem_address         aligned memory address
//   mem_read/mem_write  memory strobes
//   mem_byte_enable     write lane mask, 0 when no strobe
//   mem_wdata           memory write data
//   mem_rdata/mem_resp  memory read data and response
// -----------------------------------------------------------------------------
module lc3b_mem_seq #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic [1:0]            req_op,
   input  logic                  req_byte,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [DATA_W-1:0]     rdata,
   output logic [ADDR_W-1:0]     mem_address,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [DATA_W/8-1:0]   mem_byte_enable,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_resp
);

   localparam int LANES  = DATA_W / 8;
   localparam int LANE_W = $clog2(LANES);
   localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACC1,
      S_PTR,
      S_ACC2,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [1:0]          r_op;
   logic                r_byte;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_err;

   logic                w_in_acc;
   logic                w_ptr_phase;
   logic                w_is_write;
   logic                w_is_read;
   logic                w_byte_acc;
   logic                w_timeout;
   logic [LANE_W-1:0]   w_lane;
   logic [7:0]          w_lanes [LANES];
   logic [DATA_W-1:0]   w_wrep;
   logic [LANES-1:0]    w_onehot;

   // Phase decode. ACC1 of an indirect op is the pointer fetch, which is
   // always a word read whatever the request asked for.
   assign w_in_acc    = (r_state == S_ACC1) || (r_state == S_ACC2);
   assign w_ptr_phase = (r_state == S_ACC1) && r_op[1];
   assign w_is_write  = w_in_acc && !w_ptr_phase && r_op[0];
   assign w_is_read   = w_in_acc && !w_is_write;
   assign w_byte_acc  = r_byte && !w_ptr_phase;
   assign w_lane      = r_addr[LANE_W-1:0];
   assign w_onehot    = LANES'(1) << w_lane;

   // Lane split of read data and store-byte replication across lanes.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign w_lanes[gi]          = mem_rdata[gi*8 +: 8];
         assign w_wrep[gi*8 +: 8]    = r_wdata[7:0];
      end
   endgenerate

   // Timeout fires on the TIMEOUT-th consecutive strobe cycle without a
   // response; a response in that same cycle takes priority.
   generate
      if (TIMEOUT > 0) begin : g_to
         assign w_timeout = w_in_acc && !mem_resp && (r_cnt == CNT_W'(TIMEOUT - 1));
      end else begin : g_no_to
         assign w_timeout = 1'b0;
      end
   endgenerate

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (req) w_state_next = S_ACC1;
         S_ACC1: begin
            if (mem_resp)       w_state_next = r_op[1] ? S_PTR : S_DONE;
            else if (w_timeout) w_state_next = S_DONE;
         end
         S_PTR:  w_state_next = S_ACC2;
         S_ACC2: if (mem_resp || w_timeout) w_state_next = S_DONE;
         S_DONE: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_byte  <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_op    <= req_op;
                  r_byte  <= req_byte;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  r_err   <= 1'b0;
                  r_cnt   <= '0;
               end
            end
            S_ACC1, S_ACC2: begin
               if (mem_resp) begin
                  r_cnt <= '0;
                  if (w_ptr_phase)
                     r_addr <= ADDR_W'(mem_rdata);
                  else if (w_is_read)
                     r_rdata <= w_byte_acc ? {{(DATA_W-8){1'b0}}, w_lanes[w_lane]} : mem_rdata;
               end else if (w_timeout) begin
                  r_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_PTR:   r_cnt <= '0;
            default: ;
         endcase
      end
   end

   // Memory-side outputs depend on registers only.
   always_comb begin
      mem_address     = {r_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
      mem_read        = w_is_read;
      mem_write       = w_is_write;
      mem_wdata       = w_byte_acc ? w_wrep : r_wdata;
      mem_byte_enable = '0;
      if (w_in_acc)
         mem_byte_enable = (w_is_write && w_byte_acc) ? w_onehot : {LANES{1'b1}};
   end

   assign busy  = (r_state != S_IDLE);
   assign done  = (r_state == S_DONE);
   assign err   = (r_state == S_DONE) && r_err;
   assign rdata = r_rdata;

endmodule

// File: tb/tb_lc3b_mem_seq.sv
// -----------------------------------------------------------------------------
// tb_lc3b_mem_seq
// Directed bench for lc3b_mem_seq. Instance a: DATA_W=16, TIMEOUT=4.
// Instance b: DATA_W=32, TIMEOUT=4. Cycle 0 is the cycle in which req is
// presented; outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_lc3b_mem_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // instance a (16-bit)
   logic        a_req, a_byte, a_busy, a_done, a_err;
   logic [1:0]  a_op;
   logic [15:0] a_addr, a_wdata, a_rdata, a_mem_address, a_mem_wdata, a_mem_rdata;
   logic        a_mem_read, a_mem_write, a_mem_resp;
   logic [1:0]  a_mem_be;

   // instance b (32-bit)
   logic        b_req, b_byte, b_busy, b_done, b_err;
   logic [1:0]  b_op;
   logic [15:0] b_addr, b_mem_address;
   logic [31:0] b_wdata, b_rdata, b_mem_wdata, b_mem_rdata;
   logic        b_mem_read, b_mem_write, b_mem_resp;
   logic [3:0]  b_mem_be;

   int tests  = 0;
   int failed = 0;
   int dones;

   lc3b_mem_seq #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4)) dut_a (
      .clk(clk), .rst(rst), .req(a_req), .req_op(a_op), .req_byte(a_byte),
      .req_addr(a_addr), .req_wdata(a_wdata), .busy(a_busy), .done(a_done),
      .err(a_err), .rdata(a_rdata), .mem_address(a_mem_address),
      .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_byte_enable(a_mem_be),
      .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .mem_resp(a_mem_resp)
   );

   lc3b_mem_seq #(.DATA_W(32), .ADDR_W(16), .TIMEOUT(4)) dut_b (
      .clk(clk), .rst(rst), .req(b_req), .req_op(b_op), .req_byte(b_byte),
      .req_addr(b_addr), .req_wdata(b_wdata), .busy(b_busy), .done(b_done),
      .err(b_err), .rdata(b_rdata), .mem_address(b_mem_address),
      .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_byte_enable(b_mem_be),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_resp(b_mem_resp)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      a_req = 0; a_op = 0; a_byte = 0; a_addr = 0; a_wdata = 0; a_mem_rdata = 0; a_mem_resp = 0;
      b_req = 0; b_op = 0; b_byte = 0; b_addr = 0; b_wdata = 0; b_mem_rdata = 0; b_mem_resp = 0;
      cyc(); cyc();
      rst = 1'b0;

      // ---------------- reset state
      chk("rst_busy",  64'(a_busy), 64'd0);
      chk("rst_done",  64'(a_done), 64'd0);
      chk("rst_err",   64'(a_err), 64'd0);
      chk("rst_rd",    64'(a_mem_read), 64'd0);
      chk("rst_wr",    64'(a_mem_write), 64'd0);
      chk("rst_be",    64'(a_mem_be), 64'd0);
      chk("rst_addr",  64'(a_mem_address), 64'd0);
      chk("rst_wdata", 64'(a_mem_wdata), 64'd0);
      chk("rst_rdata", 64'(a_rdata), 64'd0);
      chk("rst_b_rdata", 64'(b_rdata), 64'd0);

      // ---------------- word read 0x0041, 3 wait cycles
      a_req = 1; a_op = 2'b00; a_byte = 0; a_addr = 16'h0041;
      cyc(); a_req = 0;                                   // cycle 1
      chk("t1_rd_c1",   64'(a_mem_read), 64'd1);
      chk("t1_addr",    64'(a_mem_address), 64'h0040);
      chk("t1_busy",    64'(a_busy), 64'd1);
      chk("t1_wr_c1",   64'(a_mem_write), 64'd0);
      cyc(); chk("t1_rd_c2", 64'(a_mem_read), 64'd1);
      cyc(); chk("t1_rd_c3", 64'(a_mem_read), 64'd1);
      cyc(); chk("t1_rd_c4", 64'(a_mem_read), 64'd1);      // cycle 4: respond
      chk("t1_nodone_c4", 64'(a_done), 64'd0);
      a_mem_resp = 1; a_mem_rdata = 16'hBEEF;
      cyc(); a_mem_resp = 0;                              // cycle 5
      chk("t1_done",  64'(a_done), 64'd1);
      chk("t1_err",   64'(a_err), 64'd0);
      chk("t1_rdata", 64'(a_rdata), 64'hBEEF);
      chk("t1_rd_c5", 64'(a_mem_read), 64'd0);
      cyc();
      chk("t1_done_c6", 64'(a_done), 64'd0);
      chk("t1_idle",    64'(a_busy), 64'd0);

      // ---------------- byte write 0x12AB to 0x0033, one wait cycle
      a_req = 1; a_op = 2'b01; a_byte = 1; a_addr = 16'h0033; a_wdata = 16'h12AB;
      cyc(); a_req = 0;
      chk("t2_wr_c1",  64'(a_mem_write), 64'd1);
      chk("t2_rd_c1",  64'(a_mem_read), 64'd0);
      chk("t2_be",     64'(a_mem_be), 64'h2);
      chk("t2_wdata",  64'(a_mem_wdata), 64'hABAB);
      chk("t2_addr",   64'(a_mem_address), 64'h0032);
      cyc();
      chk("t2_wr_c2",  64'(a_mem_write), 64'd1);
      a_mem_resp = 1;
      cyc(); a_mem_resp = 0;
      chk("t2_done",   64'(a_done), 64'd1);
      chk("t2_wr_off", 64'(a_mem_write), 64'd0);
      chk("t2_be_off", 64'(a_mem_be), 64'd0);
      chk("t2_rdata_hold", 64'(a_rdata), 64'hBEEF);
      cyc();

      // ---------------- byte write at 0x0032, zero wait
      a_req = 1; a_op = 2'b01; a_byte = 1; a_addr = 16'h0032; a_wdata = 16'h12AB;
      cyc(); a_req = 0;
      chk("t2b_be", 64'(a_mem_be), 64'h1);
      chk("t2b_wdata", 64'(a_mem_wdata), 64'hABAB);
      a_mem_resp = 1;
      cyc(); a_mem_resp = 0;
      chk("t2b_done", 64'(a_done), 64'd1);
      cyc();

      // ---------------- indirect read at 0x0100, zero wait
      a_req = 1; a_op = 2'b10; a_byte = 0; a_addr = 16'h0100;
      cyc(); a_req = 0;                                   // cycle 1 ACC1
      chk("t3_ptr_rd",   64'(a_mem_read), 64'd1);
      chk("t3_ptr_addr", 64'(a_mem_address), 64'h0100);
      a_mem_resp = 1; a_mem_rdata = 16'h2002;
      cyc(); a_mem_resp = 0;                              // cycle 2 PTR
      chk("t3_ptr_nord", 64'(a_mem_read), 64'd0);
      chk("t3_ptr_nowr", 64'(a_mem_write), 64'd0);
      chk("t3_ptr_be",   64'(a_mem_be), 64'd0);
      chk("t3_ptr_busy", 64'(a_busy), 64'd1);
      chk("t3_ptr_rdata", 64'(a_rdata), 64'hBEEF);
      cyc();                                              // cycle 3 ACC2
      chk("t3_acc2_rd",   64'(a_mem_read), 64'd1);
      chk("t3_acc2_addr", 64'(a_mem_address), 64'h2002);
      a_mem_resp = 1; a_mem_rdata = 16'h5A5A;
      cyc(); a_mem_resp = 0;                              // cycle 4
      chk("t3_done",  64'(a_done), 64'd1);
      chk("t3_rdata", 64'(a_rdata), 64'h5A5A);
      cyc();

      // ---------------- timeout, no response
      a_req = 1; a_op = 2'b00; a_byte = 0; a_addr = 16'h0010; a_mem_rdata = 16'hDEAD;
      cyc(); a_req = 0;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("t4_rd_c%0d", k), 64'(a_mem_read), 64'd1);
         chk($sformatf("t4_nodone_c%0d", k), 64'(a_done), 64'd0);
         cyc();
      end                                                 // cycle 5
      chk("t4_rd_off", 64'(a_mem_read), 64'd0);
      chk("t4_done",   64'(a_done), 64'd1);
      chk("t4_err",    64'(a_err), 64'd1);
      chk("t4_rdata",  64'(a_rdata), 64'h5A5A);
      cyc();
      chk("t4_err_c6", 64'(a_err), 64'd0);

      // ---------------- response on 4th strobe cycle wins
      a_req = 1; a_op = 2'b00; a_byte = 0; a_addr = 16'h0010;
      cyc(); a_req = 0;
      cyc(); cyc(); cyc();                                // cycle 4
      a_mem_resp = 1; a_mem_rdata = 16'h1234;
      cyc(); a_mem_resp = 0;                              // cycle 5
      chk("t4b_done",  64'(a_done), 64'd1);
      chk("t4b_err",   64'(a_err), 64'd0);
      chk("t4b_rdata", 64'(a_rdata), 64'h1234);
      cyc();

      // ---------------- reset during ACC2 of indirect write
      a_req = 1; a_op = 2'b11; a_byte = 0; a_addr = 16'h0200; a_wdata = 16'h7777;
      cyc(); a_req = 0;
      chk("t5_ptr_rd", 64'(a_mem_read), 64'd1);
      a_mem_resp = 1; a_mem_rdata = 16'h3000;
      cyc(); a_mem_resp = 0;                              // PTR
      cyc();                                              // ACC2
      chk("t5_acc2_wr",   64'(a_mem_write), 64'd1);
      chk("t5_acc2_addr", 64'(a_mem_address), 64'h3000);
      chk("t5_acc2_wd",   64'(a_mem_wdata), 64'h7777);
      chk("t5_acc2_be",   64'(a_mem_be), 64'h3);
      rst = 1;
      cyc(); rst = 0;
      chk("t5_rst_wr",   64'(a_mem_write), 64'd0);
      chk("t5_rst_busy", 64'(a_busy), 64'd0);
      chk("t5_rst_done", 64'(a_done), 64'd0);
      cyc();
      chk("t5_rst_done2", 64'(a_done), 64'd0);
      a_req = 1; a_op = 2'b01; a_byte = 0; a_addr = 16'h0044; a_wdata = 16'h5555;
      cyc(); a_req = 0;
      chk("t5_post_wr",   64'(a_mem_write), 64'd1);
      chk("t5_post_wd",   64'(a_mem_wdata), 64'h5555);
      a_mem_resp = 1;
      cyc(); a_mem_resp = 0;
      chk("t5_post_done", 64'(a_done), 64'd1);
      chk("t5_post_err",  64'(a_err), 64'd0);
      cyc();

      // ---------------- req while busy is ignored
      a_req = 1; a_op = 2'b00; a_byte = 0; a_addr = 16'h0050;
      dones = 0;
      cyc(); a_op = 2'b01; a_addr = 16'h0060;             // cycle 1, req still high
      if (a_done) dones++;
      chk("t6_rd_c1", 64'(a_mem_read), 64'd1);
      cyc();                                              // cycle 2
      if (a_done) dones++;
      chk("t6_wr_c2",   64'(a_mem_write), 64'd0);
      chk("t6_addr_c2", 64'(a_mem_address), 64'h0050);
      a_mem_resp = 1; a_mem_rdata = 16'h0F0F;
      cyc(); a_mem_resp = 0; a_req = 0;                   // cycle 3 DONE
      if (a_done) dones++;
      chk("t6_rdata", 64'(a_rdata), 64'h0F0F);
      for (int k = 4; k <= 7; k++) begin
         cyc();
         if (a_done) dones++;
      end
      chk("t6_one_done", 64'(dones), 64'd1);
      chk("t6_idle",     64'(a_busy), 64'd0);

      // ---------------- 32-bit instance: byte read, lane 3
      b_req = 1; b_op = 2'b00; b_byte = 1; b_addr = 16'h0013;
      cyc(); b_req = 0;
      chk("t7_rd",   64'(b_mem_read), 64'd1);
      chk("t7_addr", 64'(b_mem_address), 64'h0010);
      b_mem_resp = 1; b_mem_rdata = 32'hC300_0000;
      cyc(); b_mem_resp = 0;
      chk("t7_done",  64'(b_done), 64'd1);
      chk("t7_rdata", 64'(b_rdata), 64'h0000_00C3);
      cyc();

      // ---------------- 32-bit instance: byte write, lane 1
      b_req = 1; b_op = 2'b01; b_byte = 1; b_addr = 16'h0011; b_wdata = 32'h0000_345E;
      cyc(); b_req = 0;
      chk("t8_wr",    64'(b_mem_write), 64'd1);
      chk("t8_be",    64'(b_mem_be), 64'h2);
      chk("t8_wdata", 64'(b_mem_wdata), 64'h5E5E_5E5E);
      chk("t8_addr",  64'(b_mem_address), 64'h0010);
      b_mem_resp = 1;
      cyc(); b_mem_resp = 0;
      chk("t8_done",  64'(b_done), 64'd1);
      chk("t8_rdata_hold", 64'(b_rdata), 64'h0000_00C3);
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
